// File: rtl/sap1_defs.sv
// Shared definitions for the SAP-1 program loader: state codes and
// idle levels of the RAM control strobes.
package sap1_defs;

   typedef logic [3:0] ldr_state_t;

   localparam ldr_state_t IDLE      = 4'd0;
   localparam ldr_state_t WAIT_BYTE = 4'd1;
   localparam ldr_state_t SETUP     = 4'd2;
   localparam ldr_state_t WRITE     = 4'd3;
   localparam ldr_state_t HOLD      = 4'd4;
   localparam ldr_state_t RD_SETUP  = 4'd5;
   localparam ldr_state_t RD_EN     = 4'd6;
   localparam ldr_state_t RD_SAMPLE = 4'd7;
   localparam ldr_state_t CMP       = 4'd8;
   localparam ldr_state_t DONE      = 4'd9;

   localparam logic CS_IDLE  = 1'b0;
   localparam logic nWE_IDLE = 1'b1;
   localparam logic nCE_IDLE = 1'b1;

   localparam int TW = 8;

endpackage

// File: rtl/ldr_phase_timer.sv
// Down-counter that measures a bus phase; phase_end is high on the
// last cycle of a phase loaded with length len.
module ldr_phase_timer
   import sap1_defs::*;
#(
   parameter int W = TW
) (
   input  logic         clk,
   input  logic         nCLR,
   input  logic         load,
   input  logic [W-1:0] len,
   output logic         phase_end
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge nCLR) begin
      if (!nCLR) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= len - 1'b1;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign phase_end = (cnt == '0);

endmodule

// File: rtl/mem_loader.sv
// Program RAM loader: writes a byte stream into the RAM, then reads
// it back and compares the sum of the read bytes with the write sum.
module mem_loader
   import sap1_defs::*;
#(
   parameter int AW     = 4,
   parameter int DW     = 8,
   parameter int WE_CYC = 1,
   parameter int VERIFY = 1
) (
   input  logic          clk,
   input  logic          nCLR,
   input  logic          start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] ABUS,
   output logic          CS,
   output logic          nWE,
   output logic          nCE,
   inout  wire  [DW-1:0] DBUS,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] checksum
);

   ldr_state_t    state;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_byte;
   logic [DW-1:0] read_sum;
   logic          phase_end;
   logic          wr_phase;
   logic          rd_phase;
   logic          drive_en;
   logic          last;

   ldr_phase_timer #(.W(TW)) u_timer (
      .clk       (clk),
      .nCLR      (nCLR),
      .load      (state == SETUP),
      .len       (TW'(WE_CYC)),
      .phase_end (phase_end)
   );

   assign last = &addr;

   always_ff @(posedge clk or negedge nCLR) begin
      if (!nCLR) begin
         state    <= IDLE;
         addr     <= '0;
         wr_byte  <= '0;
         read_sum <= '0;
         checksum <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= WAIT_BYTE;
                  addr     <= '0;
                  read_sum <= '0;
                  checksum <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            WAIT_BYTE: begin
               if (in_valid) begin
                  wr_byte  <= in_data;
                  checksum <= checksum + in_data;
                  state    <= SETUP;
               end
            end
            SETUP: state <= WRITE;
            WRITE: begin
               if (phase_end) state <= HOLD;
            end
            HOLD: begin
               if (!last) begin
                  addr  <= addr + 1'b1;
                  state <= WAIT_BYTE;
               end else if (VERIFY != 0) begin
                  addr  <= '0;
                  state <= RD_SETUP;
               end else begin
                  state <= DONE;
               end
            end
            RD_SETUP: state <= RD_EN;
            RD_EN:    state <= RD_SAMPLE;
            RD_SAMPLE: begin
               read_sum <= read_sum + DBUS;
               if (last) begin
                  state <= CMP;
               end else begin
                  addr  <= addr + 1'b1;
                  state <= RD_SETUP;
               end
            end
            CMP: begin
               err   <= (read_sum != checksum);
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes decode straight from state so reset forces them at once.
   assign wr_phase = (state == SETUP) || (state == WRITE) ||
                     (state == HOLD);
   assign rd_phase = (state == RD_SETUP) || (state == RD_EN) ||
                     (state == RD_SAMPLE);
   assign drive_en = wr_phase;

   assign in_ready = (state == WAIT_BYTE);
   assign ABUS     = addr;
   assign CS       = (wr_phase || rd_phase) ? 1'b1 : CS_IDLE;
   assign nWE      = (state == WRITE) ? 1'b0 : nWE_IDLE;
   assign nCE      = ((state == RD_EN) || (state == RD_SAMPLE)) ?
                     1'b0 : nCE_IDLE;
   assign DBUS     = drive_en ? wr_byte : {DW{1'bz}};

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a 16x8 RAM model and a second
// instance built without read-back.
module tb_mem_loader;

   logic       clk = 1'b0;
   logic       nclr;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] abus;
   logic       cs, nwe, nce;
   logic       busy, done, err;
   logic [7:0] checksum;
   wire  [7:0] dbus;

   logic       nv_ready;
   logic [3:0] nv_abus;
   logic       nv_cs, nv_nwe, nv_nce;
   logic       nv_busy, nv_done, nv_err;
   logic [7:0] nv_checksum;
   wire  [7:0] nv_dbus;

   logic [7:0] ram [16];
   logic [7:0] bytes [16];
   bit         fault;
   int         checks = 0;
   int         errors = 0;
   int         prot = 0;
   int         nwe_lo, abus_bad, nv_lo, nv_bad;
   int         edges;

   always #5 clk = ~clk;

   mem_loader u_dut (
      .clk(clk), .nCLR(nclr), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .ABUS(abus), .CS(cs), .nWE(nwe), .nCE(nce), .DBUS(dbus),
      .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   mem_loader #(.VERIFY(0)) u_nv (
      .clk(clk), .nCLR(nclr), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(nv_ready),
      .ABUS(nv_abus), .CS(nv_cs), .nWE(nv_nwe), .nCE(nv_nce),
      .DBUS(nv_dbus), .busy(nv_busy), .done(nv_done), .err(nv_err),
      .checksum(nv_checksum)
   );

   // RAM: write on clock while selected with nWE low; bit 0 of
   // address 5 optionally stuck at zero.
   always @(posedge clk) begin
      if (cs && !nwe)
         ram[abus] <= (fault && abus == 4'd5) ? (dbus & 8'hFE) : dbus;
   end
   assign dbus = (cs && !nce) ? ram[abus] : 8'hzz;

   always @(negedge clk) begin
      if (nclr) begin
         if (!nwe && !nce) prot++;
         if (u_dut.drive_en && !nce) prot++;
         if (!nwe && $isunknown(dbus)) prot++;
         if (!nwe && !u_dut.drive_en) prot++;
         if (!nv_nwe && !nv_nce) prot++;
         if (!nv_nwe && $isunknown(nv_dbus)) prot++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic run_load(input int stall_len, input bit poke,
                           input int abort_at, output int n);
      int idx = 0;
      int stalls = 0;
      bit xfer;
      nwe_lo = 0; abus_bad = 0; nv_lo = 0; nv_bad = 0;
      n = -1;
      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_up", busy, 1'b1);
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            n = k;
            break;
         end
         if (abort_at >= 0 && !nwe && abus == abort_at[3:0]) begin
            in_valid = 1'b0;
            nclr = 1'b0;
            #1;
            chk("rst_nwe", nwe, 1'b1);
            chk("rst_cs", cs, 1'b0);
            chk("rst_nce", nce, 1'b1);
            chk("rst_drv", u_dut.drive_en, 1'b0);
            chk("rst_rdy", in_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_sum", checksum, 8'h00);
            chk("rst_abus", abus, 4'd0);
            #3;
            nclr = 1'b1;
            n = k;
            return;
         end
         if (!nwe) begin
            if (abus != nwe_lo[3:0]) abus_bad++;
            nwe_lo++;
         end
         if (!nv_nwe) begin
            if (nv_abus != nv_lo[3:0]) nv_bad++;
            nv_lo++;
         end
         if (in_ready && idx == 7 && stalls < stall_len) begin
            in_valid = 1'b0;
            stalls++;
            chk("stall_rdy", in_ready, 1'b1);
            chk("stall_nwe", nwe, 1'b1);
            chk("stall_cs", cs, 1'b0);
            chk("stall_drv", u_dut.drive_en, 1'b0);
         end else begin
            in_valid = (idx < 16);
         end
         in_data = (idx < 16) ? bytes[idx] : 8'hEE;
         start = poke && (k == 20);
         xfer = in_valid && in_ready;
         @(posedge clk);
         if (xfer) idx++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      nclr = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      fault = 1'b0;
      for (int i = 0; i < 16; i++) bytes[i] = 8'h10 + 8'(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("r_cs", cs, 1'b0);
      chk("r_nwe", nwe, 1'b1);
      chk("r_nce", nce, 1'b1);
      chk("r_drv", u_dut.drive_en, 1'b0);
      chk("r_rdy", in_ready, 1'b0);
      chk("r_flags", {busy, done, err}, 3'b000);
      chk("r_sum", checksum, 8'h00);
      chk("r_abus", abus, 4'd0);
      nclr = 1'b1;
      @(negedge clk);

      run_load(0, 1'b1, -1, edges);
      chk("full_edges", edges, 114);
      chk("full_sum", checksum, 8'h78);
      chk("full_err", err, 1'b0);
      chk("full_busy", busy, 1'b0);
      chk("full_pulses", nwe_lo, 16);
      chk("full_abus", abus_bad, 0);
      chk("ram0", ram[0], 8'h10);
      chk("ram9", ram[9], 8'h19);
      chk("ram15", ram[15], 8'h1F);
      chk("nv_done", nv_done, 1'b1);
      chk("nv_busy", nv_busy, 1'b0);
      chk("nv_sum", nv_checksum, 8'h78);
      chk("nv_abus", nv_bad, 0);

      run_load(5, 1'b0, -1, edges);
      chk("stall_edges", edges, 119);
      chk("stall_sum", checksum, 8'h78);
      chk("stall_pulses", nwe_lo, 16);
      chk("stall_abus", abus_bad, 0);
      chk("stall_err", err, 1'b0);

      fault = 1'b1;
      bytes[5] = 8'h21;
      run_load(0, 1'b0, -1, edges);
      chk("vf_edges", edges, 114);
      chk("vf_sum", checksum, 8'h84);
      chk("vf_ram5", ram[5], 8'h20);
      chk("vf_err", err, 1'b1);
      chk("vf_done", done, 1'b1);
      chk("vf_nv_err", nv_err, 1'b0);
      chk("vf_nv_done", nv_done, 1'b1);
      fault = 1'b0;
      bytes[5] = 8'h15;

      run_load(0, 1'b0, 9, edges);
      chk("abort_pulses", nwe_lo, 9);
      run_load(0, 1'b0, -1, edges);
      chk("rl_edges", edges, 114);
      chk("rl_sum", checksum, 8'h78);
      chk("rl_abus", abus_bad, 0);
      chk("rl_err", err, 1'b0);
      chk("rl_ram9", ram[9], 8'h19);
      chk("rl_nv_cs", nv_cs, 1'b0);
      chk("rl_nv_rdy", nv_ready, 1'b0);

      chk("proto", prot, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
# mem_loader

Bus initiator that fills the 16×8 program RAM from a byte stream and then reads it back to verify the load. It drives the RAM's address bus, chip select, active-low write and output enables, and the shared bidirectional data bus. It sits between the front-panel/serial byte source and the RAM, and is the only master of the RAM bus during a load.

## Interface
Parameters:
- `AW`, 4, address width; the RAM depth is 2^AW.
- `DW`, 8, data width.
- `WE_CYC`, 1, number of cycles `nWE` is held low per write (≥1).
- `VERIFY`, 1, enables the read-back phase when set to 1.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `nCLR`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load; ignored while `busy`.
- `in_data`  in  DW  byte to write.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `ABUS`  out  AW  RAM address.
- `CS`  out  1  RAM chip select, active high.
- `nWE`  out  1  RAM write enable, active low.
- `nCE`  out  1  RAM output enable, active low.
- `DBUS`  inout  DW  shared data bus; the loader drives it or leaves it high-Z.
- `busy`  out  1  a load or verify is in progress.
- `done`  out  1  sticky; the load has completed.
- `err`  out  1  sticky; the verify checksum did not match.
- `checksum`  out  DW  sum of all written bytes, mod 2^DW.

## Operation
- **Reset values (async):** `ABUS`=0, `CS`=0, `nWE`=1, `nCE`=1, `DBUS`=Z, `in_ready`=0, `busy`=0, `done`=0, `err`=0, `checksum`=0, state IDLE.
- **States:**
  - IDLE → WAIT_BYTE on `start`. This clears `done`, `err`, `checksum` and the address counter.
  - WAIT_BYTE → SETUP on `in_valid && in_ready`. The byte is latched and added to `checksum`.
  - SETUP (1 cycle) → WRITE (`WE_CYC` cycles) → HOLD (1 cycle).
  - From HOLD:
    - If the address is not last, go to WAIT_BYTE with the address incremented.
    - If the address is last and `VERIFY`=1, go to RD_SETUP with the address set to 0.
    - If the address is last and `VERIFY`=0, go to DONE.
  - Read loop: RD_SETUP → RD_EN → RD_SAMPLE. After RD_SAMPLE, go to RD_SETUP with the address incremented, or to CMP after the last address.
  - CMP (1 cycle): set `err` if `read_sum` ≠ `checksum`, then go to DONE.
  - DONE sets `done`=1, `busy`=0 and returns to IDLE.
- **Handshake:** `in_ready`=1 only in WAIT_BYTE, regardless of `in_valid`. A byte transfers on any edge where both `in_valid` and `in_ready` are high. `in_valid` outside WAIT_BYTE is ignored and no byte is consumed.
- **Write cycle:**
  - `CS`=1 from SETUP through HOLD.
  - `ABUS` and the `DBUS` drive are stable from SETUP through HOLD.
  - `nWE`=0 only in WRITE.
  - `nCE`=1 throughout the write cycle.
- **Read cycle:**
  - RD_SETUP: `DBUS`=Z, `CS`=1, `nWE`=1, `nCE`=1.
  - RD_EN and RD_SAMPLE: `nCE`=0.
  - `DBUS` is sampled at the end of RD_SAMPLE and added to `read_sum` mod 2^DW.
- **Bus rules:**
  - The loader drives `DBUS` only when `nWE`=1 or in WRITE, and never while `nCE`=0.
  - `nWE` and `nCE` are never both 0.
  - `CS`=0 and `DBUS`=Z in IDLE and DONE.
- **Address counter:** AW bits; it wraps from 2^AW−1 to 0 when entering verify. `checksum` and `read_sum` wrap mod 2^DW.
- **Simultaneous events:**
  - `start` while `busy` is ignored.
  - `start` in the same cycle as `done` is allowed and begins a new load.
- **Reset mid-operation:** all outputs return to their reset values immediately and asynchronously. `nWE` rises without waiting for a clock. The RAM byte at the current address is then undefined. The next `start` reloads from address 0.

## Timing
- Write cost per byte, once the byte is accepted: 2+`WE_CYC` cycles (SETUP, WRITE, HOLD).
- WAIT_BYTE lasts at least 1 cycle. With `in_valid` held high, each byte costs 3+`WE_CYC` cycles.
- Verify cost: 3 cycles per address plus 1 CMP cycle.
- Defaults, continuous `in_valid`, `start` sampled on edge 0:
  - `busy` rises after edge 0.
  - `done` rises after edge 1+64+48+1 = 114.
- `busy` falls in the same cycle `done` rises.

## Structure
- A shared package `sap1_defs` holds:
  - the state encoding `ldr_state_t` (IDLE, WAIT_BYTE, SETUP, WRITE, HOLD, RD_SETUP, RD_EN, RD_SAMPLE, CMP, DONE);
  - bus idle constants (`CS_IDLE`=0, `nWE_IDLE`=1, `nCE_IDLE`=1).
- One sub-module, `ldr_phase_timer`, is a small down-counter loaded with the phase length (`WE_CYC`, 1). It pulses `phase_end` so the FSM does not hard-code cycle counts.
- The tri-state driver lives in the top level: `DBUS` = `drive_en` ? `wr_byte` : Z.

## Test plan
1. **Reset:** assert `nCLR`=0 mid-clock → `CS`=0, `nWE`=1, `nCE`=1, `DBUS`=Z, `in_ready`=0, `busy`/`done`/`err`=0, `checksum`=0 without waiting for a clock edge.
2. **Full load:** behavioural RAM model, bytes 0x10..0x1F with continuous `in_valid` → `ABUS` steps 0..15, one `nWE` low pulse of 1 cycle per address, RAM holds 0x10..0x1F, `checksum`=0x78, `err`=0, `done` after edge 114.
3. **Stalls:** drop `in_valid` for 5 cycles before byte 7 → `in_ready` stays 1, `nWE`=1, `CS`=0, `DBUS`=Z during the stall, no extra byte consumed, `done` 5 cycles later.
4. **Verify failure:** RAM model with bit 0 of address 5 stuck at 0, byte 0x21 written there → `err`=1 and `done`=1. With `VERIFY`=0, the same stimulus gives `err`=0.
5. **Bus protocol and start-while-busy:**
   - Assertions: never `nWE`=0 && `nCE`=0; never loader drive while `nCE`=0; `DBUS` is not X while `nWE`=0.
   - `start` pulsed at cycle 20 of a load → ignored; the address sequence is unchanged.
6. **Reset mid-write:** `nCLR` low while `nWE`=0 at address 9 → `nWE`=1 asynchronously. After release and a new `start`, the reload begins at `ABUS`=0 and `checksum` restarts from 0.
